mmio_burst_sequencer: RTL

//  Parametrised successor to the single-word switch->mem->LED state controller.
//  On start, moves DEPTH words SRC -> data memory (staging), then data memory -> DST.

---
 rtl/mmio_burst_sequencer_pkg.sv | 27 ++
 rtl/mmio_burst_sequencer_if.sv | 26 ++
 rtl/mmio_ack_timer.sv | 42 ++++
 rtl/mmio_burst_sequencer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mmio_burst_sequencer_pkg.sv
// Shared definitions for the MMIO burst sequencer and the address decoder
// that sits behind it: state encoding and the default memory map.
package mmio_burst_sequencer_pkg;

  // Sequencer states. The decoder reuses this encoding to attribute bus traffic.
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_READ_IN   = 3'd1,
    S_WRITE_MEM = 3'd2,
    S_READ_MEM  = 3'd3,
    S_WRITE_OUT = 3'd4,
    S_DONE      = 3'd5,
    S_ERR       = 3'd6
  } state_e;

  // Default memory map: switches, data memory (staging), LEDs.
  localparam logic [31:0] DEF_SRC_BASE = 32'h8000_0000;
  localparam logic [31:0] DEF_BUF_BASE = 32'h0000_0000;
  localparam logic [31:0] DEF_DST_BASE = 32'h4000_0000;

  // True in the states that own a bus access and wait for bus_ack.
  function automatic logic is_access(input state_e s);
    return (s == S_READ_IN) || (s == S_WRITE_MEM) ||
           (s == S_READ_MEM) || (s == S_WRITE_OUT);
  endfunction

endpackage

// File: rtl/mmio_burst_sequencer_if.sv
// Shared MMIO bus seen by the sequencer (master) and the address decoder (slave).
// Strobes, address and write data come from the master; the slave answers with
// bus_ack and, for reads, bus_rdata in the same cycle.
interface mmio_burst_sequencer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_re;
  logic              bus_we;
  logic              bus_ack;

  modport master (
    output bus_addr, bus_wdata, bus_re, bus_we,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_addr, bus_wdata, bus_re, bus_we,
    output bus_rdata, bus_ack
  );

endinterface

// File: rtl/mmio_ack_timer.sv
// Per-access acknowledge timer. Counts cycles spent waiting for bus_ack and
// flags the cycle in which the wait reaches TIMEOUT cycles.
module mmio_ack_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int            TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] count_q, count_d;

  // Next count: clear wins over increment.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave it unassigned (latch).
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // The TIMEOUT-th waiting cycle without an ack.
  assign expired_o = enable_i && (count_q == LAST);

endmodule

// File: rtl/mmio_burst_sequencer.sv
// MMIO burst sequencer: copies DEPTH words source -> data memory, then data
// memory -> destination, mastering the shared bus with a req/ack handshake
// and a per-access timeout. Supports one-shot and continuous operation.
module mmio_burst_sequencer
  import mmio_burst_sequencer_pkg::*;
#(
  parameter int              DATA_W   = 32,
  parameter int              ADDR_W   = 32,
  parameter int              DEPTH    = 4,
  parameter logic [ADDR_W-1:0] SRC_BASE = ADDR_W'(DEF_SRC_BASE),
  parameter logic [ADDR_W-1:0] BUF_BASE = ADDR_W'(DEF_BUF_BASE),
  parameter logic [ADDR_W-1:0] DST_BASE = ADDR_W'(DEF_DST_BASE),
  parameter bit              SRC_INC  = 1'b0,
  parameter bit              DST_INC  = 1'b0,
  parameter int              STRIDE   = 4,
  parameter int              TIMEOUT  = 255,
  localparam int             CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             cont_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             timeout_err_o,
  output logic [CNT_W-1:0] word_idx_o,
  mmio_burst_sequencer_if.master bus
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              re_q, re_d;
  logic              we_q, we_d;
  logic              terr_q, terr_d;
  logic              waiting;
  logic              tmr_expired;

  // Address of word idx in a region; the step is skipped for fixed-address
  // devices. Wraps modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                   input logic             step,
                                                   input logic [CNT_W-1:0] idx);
    logic [ADDR_W-1:0] offset;
    offset = step ? (ADDR_W'(idx) * ADDR_W'(STRIDE)) : '0;
    return base + offset;
  endfunction

  // An access is outstanding and this cycle brought no ack.
  assign waiting = is_access(state_q) && !bus.bus_ack;

  mmio_ack_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_ack_timer (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (!waiting),
    .enable_i  (waiting),
    .expired_o (tmr_expired)
  );

  // Next state, index, hold data and the strobes/address for the state being entered.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    terr_d  = terr_q;

    if (tmr_expired) begin
      // Only reachable while waiting, so an ack in this cycle has already won.
      state_d = S_ERR;
      terr_d  = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_d = S_READ_IN;
            idx_d   = '0;
            terr_d  = 1'b0;
          end
        end
        S_READ_IN: begin
          if (bus.bus_ack) begin
            hold_d  = bus.bus_rdata;
            state_d = S_WRITE_MEM;
          end
        end
        S_WRITE_MEM: begin
          if (bus.bus_ack) begin
            if (idx_q == LAST_IDX) begin
              idx_d   = '0;
              state_d = S_READ_MEM;
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = S_READ_IN;
            end
          end
        end
        S_READ_MEM: begin
          if (bus.bus_ack) begin
            hold_d  = bus.bus_rdata;
            state_d = S_WRITE_OUT;
          end
        end
        S_WRITE_OUT: begin
          if (bus.bus_ack) begin
            if (idx_q == LAST_IDX) begin
              state_d = S_DONE;
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = S_READ_MEM;
            end
          end
        end
        S_DONE: begin
          idx_d   = '0;
          state_d = cont_i ? S_READ_IN : S_IDLE;
        end
        S_ERR: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    // Bus outputs are registered from the next state, so they rise on state
    // entry and stay constant while the access waits for its ack.
    re_d    = 1'b0;
    we_d    = 1'b0;
    addr_d  = '0;
    wdata_d = '0;
    unique case (state_d)
      S_READ_IN: begin
        re_d   = 1'b1;
        addr_d = word_addr(SRC_BASE, SRC_INC, idx_d);
      end
      S_WRITE_MEM: begin
        we_d    = 1'b1;
        addr_d  = word_addr(BUF_BASE, 1'b1, idx_d);
        wdata_d = hold_d;
      end
      S_READ_MEM: begin
        re_d   = 1'b1;
        addr_d = word_addr(BUF_BASE, 1'b1, idx_d);
      end
      S_WRITE_OUT: begin
        we_d    = 1'b1;
        addr_d  = word_addr(DST_BASE, DST_INC, idx_d);
        wdata_d = hold_d;
      end
      default: begin
        re_d = 1'b0;
      end
    endcase
  end

  // State, index, hold register and registered bus outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      hold_q  <= '0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
      re_q    <= re_d;
      we_q    <= we_d;
      terr_q  <= terr_d;
    end
  end

  assign bus.bus_addr  = addr_q;
  assign bus.bus_wdata = wdata_q;
  assign bus.bus_re    = re_q;
  assign bus.bus_we    = we_q;

  assign busy_o        = (state_q != S_IDLE);
  assign done_o        = (state_q == S_DONE);
  assign timeout_err_o = terr_q;
  assign word_idx_o    = idx_q;

endmodule
